// File: rtl/seg_scan_if.sv
// Host/board-side signal bundle of the 7-segment scan controller.
// The master side drives load data and the external decoder output; the slave is the controller.
interface seg_scan_if #(
   parameter int unsigned DIGITS = 8
);
   logic                  load;
   logic [4*DIGITS-1:0]   data;
   logic [DIGITS-1:0]     dp_mask;
   logic [DIGITS-1:0]     en_mask;
   logic [3:0]            hex_out;
   logic [7:0]            seg_in;
   logic [7:0]            seg_out;
   logic [DIGITS-1:0]     an;
   logic                  load_ack;
   logic                  frame_start;

   modport master (
      output load, data, dp_mask, en_mask, seg_in,
      input  hex_out, seg_out, an, load_ack, frame_start
   );

   modport slave (
      input  load, data, dp_mask, en_mask, seg_in,
      output hex_out, seg_out, an, load_ack, frame_start
   );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scan controller with double-buffered
// host data that only takes effect at a frame boundary.
module seg_scan_ctrl #(
   parameter int unsigned DIGITS    = 8,
   parameter int unsigned CLK_DIV   = 50000,
   parameter int unsigned BLANK_CYC = 500
) (
   input  logic     clk,
   input  logic     rst,
   seg_scan_if.slave bus
);
   localparam int unsigned CW = $clog2(CLK_DIV);
   localparam int unsigned IW = $clog2(DIGITS);

   typedef enum logic {S_BLANK, S_SHOW} state_e;

   state_e              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [IW-1:0]       idx_q, idx_d;

   logic [4*DIGITS-1:0] pend_data_q, act_data_q;
   logic [DIGITS-1:0]   pend_dp_q, pend_en_q, act_dp_q, act_en_q;
   logic                pend_vld_q;

   logic [DIGITS-1:0]   an_q, an_d;
   logic [7:0]          seg_q, seg_d;
   logic                ack_q, ack_d;
   logic                fs_q, fs_d;

   logic                blank_end, slot_end, last_digit, wrap;

   assign blank_end  = (cnt_q == CW'(BLANK_CYC - 1));
   assign slot_end   = (cnt_q == CW'(CLK_DIV - 1));
   assign last_digit = (idx_q == IW'(DIGITS - 1));
   assign wrap       = (state_q == S_SHOW) && slot_end && last_digit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_BLANK;
         cnt_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
      end
   end

   // One counter spans the whole slot; the state only marks where blanking ends.
   always_comb begin
      state_d = state_q;
      cnt_d   = slot_end ? '0 : cnt_q + CW'(1);
      idx_d   = idx_q;
      case (state_q)
         S_BLANK: if (blank_end) state_d = S_SHOW;
         S_SHOW: begin
            if (slot_end) begin
               state_d = S_BLANK;
               idx_d   = last_digit ? '0 : idx_q + IW'(1);
            end
         end
         default: state_d = S_BLANK;
      endcase
   end

   always_comb begin
      an_d  = '1;
      seg_d = 8'hFF;
      if ((state_q == S_SHOW) && act_en_q[idx_q]) begin
         an_d[idx_q] = 1'b0;
         seg_d       = {bus.seg_in[7:1], bus.seg_in[0] & ~act_dp_q[idx_q]};
      end
      ack_d = wrap && pend_vld_q;
      fs_d  = wrap;
   end

   // A load on the apply cycle lands in pending after the old pending moved to active.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_data_q <= '0;
         pend_dp_q   <= '0;
         pend_en_q   <= '0;
         pend_vld_q  <= 1'b0;
         act_data_q  <= '0;
         act_dp_q    <= '0;
         act_en_q    <= '0;
         an_q        <= '1;
         seg_q       <= 8'hFF;
         ack_q       <= 1'b0;
         fs_q        <= 1'b0;
      end else begin
         if (wrap && pend_vld_q) begin
            act_data_q <= pend_data_q;
            act_dp_q   <= pend_dp_q;
            act_en_q   <= pend_en_q;
         end
         if (bus.load) begin
            pend_data_q <= bus.data;
            pend_dp_q   <= bus.dp_mask;
            pend_en_q   <= bus.en_mask;
            pend_vld_q  <= 1'b1;
         end else if (wrap) begin
            pend_vld_q  <= 1'b0;
         end
         an_q  <= an_d;
         seg_q <= seg_d;
         ack_q <= ack_d;
         fs_q  <= fs_d;
      end
   end

   assign bus.hex_out     = act_data_q[{idx_q, 2'b00} +: 4];
   assign bus.an          = an_q;
   assign bus.seg_out     = seg_q;
   assign bus.load_ack    = ack_q;
   assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random loads, each cycle
// compared against a position-in-frame reference model.
module tb_seg_scan_ctrl;
   localparam int unsigned DIG   = 4;
   localparam int unsigned CLK   = 8;
   localparam int unsigned BLK   = 2;
   localparam int unsigned FRAME = DIG * CLK;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;

   seg_scan_if #(.DIGITS(DIG)) bus ();

   seg_scan_ctrl #(.DIGITS(DIG), .CLK_DIV(CLK), .BLANK_CYC(BLK)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // External hex decoder: active-low {a,b,c,d,e,f,g,dp}, dp off.
   function automatic logic [7:0] seghex(input logic [3:0] n);
      logic [6:0] p;
      case (n)
         4'h0: p = 7'h7E; 4'h1: p = 7'h30; 4'h2: p = 7'h6D; 4'h3: p = 7'h79;
         4'h4: p = 7'h33; 4'h5: p = 7'h5B; 4'h6: p = 7'h5F; 4'h7: p = 7'h70;
         4'h8: p = 7'h7F; 4'h9: p = 7'h7B; 4'hA: p = 7'h77; 4'hB: p = 7'h1F;
         4'hC: p = 7'h4E; 4'hD: p = 7'h3D; 4'hE: p = 7'h4F; default: p = 7'h47;
      endcase
      return {~p, 1'b1};
   endfunction

   assign bus.seg_in = seghex(bus.hex_out);

   int unsigned ecount;
   logic [15:0] m_data, p_data;
   logic [3:0]  m_dp, m_en, p_dp, p_en;
   logic        m_pv;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      ecount = 0;
      m_data = '0; m_dp = '0; m_en = '0;
      p_data = '0; p_dp = '0; p_en = '0;
      m_pv   = 1'b0;
   endtask

   task automatic tick(input logic ld, input logic [15:0] d, input logic [3:0] dp,
                       input logic [3:0] en);
      int unsigned pos, idx, nidx;
      logic [7:0]  s, es;
      logic [3:0]  ea;
      logic        wr, ea_ack;
      bus.load = ld; bus.data = d; bus.dp_mask = dp; bus.en_mask = en;
      @(posedge clk);
      pos = ecount;
      ecount++;
      idx = (pos / CLK) % DIG;
      ea = '1; es = 8'hFF;
      if ((pos % CLK) >= BLK && m_en[idx]) begin
         ea[idx] = 1'b0;
         s  = seghex(m_data[idx*4 +: 4]);
         es = {s[7:1], s[0] & ~m_dp[idx]};
      end
      wr = ((pos % FRAME) == FRAME - 1);
      ea_ack = wr && m_pv;
      if (wr && m_pv) begin
         m_data = p_data; m_dp = p_dp; m_en = p_en; m_pv = 1'b0;
      end
      if (ld) begin
         p_data = d; p_dp = dp; p_en = en; m_pv = 1'b1;
      end
      nidx = (ecount / CLK) % DIG;
      #1;
      bus.load = 1'b0;
      chk("an", 32'(bus.an), 32'(ea));
      chk("seg_out", 32'(bus.seg_out), 32'(es));
      chk("load_ack", 32'(bus.load_ack), 32'(ea_ack));
      chk("frame_start", 32'(bus.frame_start), 32'(wr));
      chk("hex_out", 32'(bus.hex_out), 32'(m_data[nidx*4 +: 4]));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, '0, '0, '0);
   endtask

   task automatic to_phase(input int unsigned ph);
      for (int i = 0; i < 2 * FRAME && (ecount % FRAME) != ph; i++) tick(1'b0, '0, '0, '0);
      chk("phase_reach", ecount % FRAME, ph);
   endtask

   initial begin
      rst = 1'b1;
      bus.load = 1'b0; bus.data = '0; bus.dp_mask = '0; bus.en_mask = '0;
      model_reset();
      #2;
      chk("rst_an", 32'(bus.an), 32'hF);
      chk("rst_seg", 32'(bus.seg_out), 32'hFF);
      chk("rst_ack", 32'(bus.load_ack), 0);
      chk("rst_fs", 32'(bus.frame_start), 0);
      #1 rst = 1'b0;

      // Dark for three frames, frame_start each wrap, no ack.
      idle(3 * FRAME);

      // Full digit set, checked against fixed decoder patterns too.
      tick(1'b1, 16'h3210, 4'h0, 4'hF);
      to_phase(0);
      to_phase(3);
      chk("d0_an", 32'(bus.an), 32'hE);
      chk("d0_seg", 32'(bus.seg_out), 32'h03);
      to_phase(11);
      chk("d1_an", 32'(bus.an), 32'hD);
      chk("d1_seg", 32'(bus.seg_out), 32'h9F);

      // Sparse enable with one decimal point.
      tick(1'b1, 16'h3210, 4'b0100, 4'b0101);
      to_phase(0);
      to_phase(11);
      chk("dark1_an", 32'(bus.an), 32'hF);
      chk("dark1_seg", 32'(bus.seg_out), 32'hFF);
      to_phase(19);
      chk("dp2_an", 32'(bus.an), 32'hB);
      chk("dp2_seg", 32'(bus.seg_out), 32'h24);

      // Two loads in one frame: latest wins, one ack.
      to_phase(2);
      tick(1'b1, 16'hAAAA, 4'h0, 4'hF);
      to_phase(10);
      tick(1'b1, 16'h5555, 4'h0, 4'hF);
      to_phase(0);
      to_phase(3);
      chk("latest_seg", 32'(bus.seg_out), 32'h49);

      // Load coinciding with apply.
      tick(1'b1, 16'h1111, 4'h0, 4'hF);
      to_phase(31);
      tick(1'b1, 16'h2222, 4'h0, 4'hF);
      to_phase(3);
      chk("old_first_seg", 32'(bus.seg_out), 32'h9F);
      to_phase(0);
      to_phase(3);
      chk("new_next_seg", 32'(bus.seg_out), 32'h25);

      // Asynchronous reset during digit 2 show slot.
      to_phase(20);
      chk("pre_rst_an", 32'(bus.an), 32'hB);
      #2 rst = 1'b1;
      #1;
      chk("async_an", 32'(bus.an), 32'hF);
      chk("async_seg", 32'(bus.seg_out), 32'hFF);
      chk("async_ack", 32'(bus.load_ack), 0);
      chk("async_fs", 32'(bus.frame_start), 0);
      @(negedge clk) rst = 1'b0;
      model_reset();
      chk("post_rst_hex", 32'(bus.hex_out), 0);
      idle(2 * FRAME);
      tick(1'b1, 16'h0123, 4'h0, 4'hF);
      idle(2 * FRAME);

      // Random loads of random content.
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 15) == 0)
            tick(1'b1, 16'($urandom()), 4'($urandom()), 4'($urandom()));
         else
            tick(1'b0, 16'($urandom()), 4'($urandom()), 4'($urandom()));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
